// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the SDF FFT control path.
// Stage offsets and total latency are counted in pipe_en cycles.
package fft_pkg;

    localparam int LOG2N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Enables consumed by stages 0..s-1: each stage delays by N>>(k+1) plus its butterfly registers.
    function automatic int stage_off(input int s, input int log2n, input int bf_lat);
        int acc;
        acc = 0;
        for (int k = 0; k < s; k++) begin
            acc += ((1 << log2n) >> (k + 1)) + bf_lat;
        end
        return acc;
    endfunction

    function automatic int pipe_latency(input int log2n, input int bf_lat);
        return stage_off(log2n, log2n, bf_lat);
    endfunction

endpackage

// File: rtl/en_delay.sv
// Enable-gated WIDTH x DELAY shift register; DELAY enables from din to dout.
// No backpressure: it advances only when en is high and holds otherwise.
module en_delay #(
    parameter int WIDTH = 3,
    parameter int DELAY = 19
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DELAY-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[DELAY-2:0], din};
        end
    end

    assign dout = sr[DELAY-1];

endmodule

// File: rtl/fft_sdf_sequencer.sv
// SDF FFT sequencer: input handshake, pipe_en, stage selects and output tags (LATENCY+1 enables).
// in_ready drops only while draining; there is no downstream backpressure.
module fft_sdf_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEF,
    parameter int BF_LAT = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_flush,
    output logic             in_ready,
    output logic             pipe_en,
    output logic [LOG2N-1:0] stage_sel,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             busy,
    output logic             err_frame
);

    localparam int N       = 1 << LOG2N;
    localparam int LATENCY = pipe_latency(LOG2N, BF_LAT);
    localparam int CW      = $clog2(LATENCY + 1);
    localparam logic [LOG2N-1:0] POS_LAST = LOG2N'(N - 1);

    state_t           state;
    logic [LOG2N-1:0] pos;
    logic [CW-1:0]    drain_cnt;
    logic             acc;
    logic [2:0]       tag_in;
    logic [2:0]       tag_out;

    assign in_ready = (state != DRAIN);
    assign busy     = (state != IDLE);
    assign acc      = in_valid & in_ready;
    assign pipe_en  = (state == DRAIN) | in_valid;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            pos       <= '0;
            drain_cnt <= '0;
            err_frame <= 1'b0;
        end else begin
            if (pipe_en) begin
                pos <= pos + 1'b1;
            end
            // A short frame resyncs the counter so the next beat starts a fresh frame.
            if (acc & in_last & (pos != POS_LAST)) begin
                err_frame <= 1'b1;
                pos       <= '0;
            end
            case (state)
                IDLE: begin
                    if (acc) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (acc & in_last & in_flush) begin
                        state     <= DRAIN;
                        drain_cnt <= CW'(LATENCY);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == CW'(1)) begin
                        state     <= IDLE;
                        pos       <= '0;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage s sees the sample stream OFF_s enables late; its mode is the top-down bit s of that phase.
    for (genvar s = 0; s < LOG2N; s++) begin : g_sel
        localparam logic [LOG2N-1:0] OFF_S    = LOG2N'(stage_off(s, LOG2N, BF_LAT) % N);
        localparam logic [LOG2N-1:0] SEL_MASK = LOG2N'(1 << (LOG2N - 1 - s));
        assign stage_sel[s] = |((pos - OFF_S) & SEL_MASK);
    end

    assign tag_in = {acc, acc & (pos == '0), acc & in_last};

    en_delay #(
        .WIDTH(3),
        .DELAY(LATENCY)
    ) u_tag_dly (
        .clk    (clk),
        .clear_n(clear_n),
        .en     (pipe_en),
        .din    (tag_in),
        .dout   (tag_out)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            {out_valid, out_sof, out_eof} <= 3'b000;
        end else if (pipe_en) begin
            {out_valid, out_sof, out_eof} <= tag_out;
        end
    end

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Self-checking bench for fft_sdf_sequencer (N = 16, BF_LAT = 1, LATENCY = 19).
module tb_fft_sdf_sequencer;

    logic       clk = 1'b0;
    logic       clear_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_flush = 1'b0;
    logic       in_ready, pipe_en, out_valid, out_sof, out_eof, busy, err_frame;
    logic [3:0] stage_sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_sdf_sequencer #(.LOG2N(4), .BF_LAT(1)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_flush (in_flush),
        .in_ready (in_ready),
        .pipe_en  (pipe_en),
        .stage_sel(stage_sel),
        .out_valid(out_valid),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .busy     (busy),
        .err_frame(err_frame)
    );

    // Reference model: mode 0 idle, 1 streaming, 2 draining; tags indexed by enable number.
    int         m_mode, m_cnt, m_pos, m_edges;
    logic       m_err;
    logic [2:0] m_out;
    logic [2:0] inj [0:8191];
    logic       last_pe;
    logic [6:0] pre_obs, pre_exp;
    logic [3:0] post_obs, post_exp;

    function automatic logic [3:0] exp_sel(input int p);
        logic [3:0] r;
        int off, ph;
        off = 0;
        for (int s = 0; s < 4; s++) begin
            ph = (((p - off) % 16) + 16) % 16;
            r[s] = ph[3 - s];
            off += (16 >> (s + 1)) + 1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pos = 0; m_edges = 0; m_err = 1'b0; m_out = 3'b000;
    endtask

    task automatic model_step(input logic v, input logic l, input logic f);
        logic acc, pe;
        acc = v && (m_mode != 2);
        pe  = (m_mode == 2) || v;
        if (pe) begin
            m_edges++;
            inj[m_edges] = acc ? {1'b1, m_pos == 0, l} : 3'b000;
            m_out = (m_edges > 19) ? inj[m_edges - 19] : 3'b000;
        end
        if (acc && l && m_pos != 15) begin
            m_err = 1'b1;
            m_pos = 0;
        end else if (pe) begin
            m_pos = (m_pos + 1) % 16;
        end
        if (m_mode == 2) begin
            if (m_cnt == 1) begin m_mode = 0; m_pos = 0; end
            else m_cnt--;
        end else if (m_mode == 1) begin
            if (acc && l && f) begin m_mode = 2; m_cnt = 19; end
        end else if (acc) begin
            m_mode = 1;
        end
    endtask

    task automatic tick(input logic v, input logic l, input logic f);
        @(negedge clk);
        in_valid = v; in_last = l; in_flush = f;
        #1;
        last_pe = (m_mode == 2) || v;
        pre_exp = {m_mode != 2, last_pe, m_mode != 0, exp_sel(m_pos)};
        pre_obs = {in_ready, pipe_en, busy, stage_sel};
        @(posedge clk);
        #1;
        model_step(v, l, f);
        post_exp = {m_out, m_err};
        post_obs = {out_valid, out_sof, out_eof, err_frame};
    endtask

    task automatic test_reset();
        clear_n = 1'b1;
        #2 clear_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({in_ready, pipe_en, busy, stage_sel} !== {3'b100, exp_sel(0)}) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=%b", {in_ready, pipe_en, busy, stage_sel}, {3'b100, exp_sel(0)});
        end
        checks++;
        if ({out_valid, out_sof, out_eof, err_frame} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_out got=%b want=0000", {out_valid, out_sof, out_eof, err_frame});
        end
        #12;
        @(negedge clk) clear_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int en_seen, sof_edge, eof_edge, vcnt, dcnt;
        en_seen = 0; sof_edge = -1; eof_edge = -1; vcnt = 0; dcnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (i < 16) tick(1'b1, i == 15, i == 15);
            else if (m_mode != 0 || i < 38) tick(1'b0, 1'b0, 1'b0);
            else break;
            checks += 2;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL single_ctrl cyc=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL single_out cyc=%0d got=%b want=%b", i, post_obs, post_exp); end
            if (pre_obs[5]) begin
                en_seen++;
                if (out_valid) vcnt++;
                if (out_sof && sof_edge < 0) sof_edge = en_seen;
                if (out_eof && eof_edge < 0) eof_edge = en_seen;
            end
            if (pre_obs[4] && !pre_obs[6]) dcnt++;
        end
        checks += 4;
        if (sof_edge != 20) begin failures++; $display("FAIL single_sof_edge got=%0d want=20", sof_edge); end
        if (eof_edge != 35) begin failures++; $display("FAIL single_eof_edge got=%0d want=35", eof_edge); end
        if (vcnt != 16) begin failures++; $display("FAIL single_valid_count got=%0d want=16", vcnt); end
        if (dcnt != 19) begin failures++; $display("FAIL single_drain_cycles got=%0d want=19", dcnt); end
    endtask

    task automatic test_stage_sel();
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, i == 15, 1'b0);
            checks += 4;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL sel_ctrl pos=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL sel_out pos=%0d got=%b want=%b", i, post_obs, post_exp); end
            if (pre_obs[0] !== (i >= 8)) begin failures++; $display("FAIL sel0 pos=%0d got=%b want=%b", i, pre_obs[0], i >= 8); end
            if (pre_obs[1] !== (i inside {0, 5, 6, 7, 8, 13, 14, 15})) begin
                failures++; $display("FAIL sel1 pos=%0d got=%b", i, pre_obs[1]);
            end
        end
    endtask

    task automatic test_stall();
        int beats, stalled_en;
        logic [3:0] frozen;
        beats = 0; stalled_en = 0; frozen = 4'h0;
        for (int i = 0; i < 19; i++) begin
            if (i >= 6 && i < 9) tick(1'b0, 1'b0, 1'b0);
            else begin beats++; tick(1'b1, beats == 16, 1'b0); end
            checks += 2;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL stall_ctrl cyc=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL stall_out cyc=%0d got=%b want=%b", i, post_obs, post_exp); end
            if (i == 6) frozen = pre_obs[3:0];
            if (i >= 6 && i < 9) begin
                if (pre_obs[5]) stalled_en++;
                checks++;
                if (pre_obs[3:0] !== frozen) begin failures++; $display("FAIL stall_frozen cyc=%0d got=%b want=%b", i, pre_obs[3:0], frozen); end
            end
        end
        checks++;
        if (stalled_en != 0) begin failures++; $display("FAIL stall_pipe_en got=%0d want=0", stalled_en); end
    endtask

    task automatic test_misaligned();
        for (int i = 0; i < 60; i++) begin
            if (i < 10) tick(1'b1, i == 9, 1'b0);
            else if (i < 26) tick(1'b1, i == 25, i == 25);
            else if (m_mode != 0) tick(1'b0, 1'b0, 1'b0);
            else break;
            checks += 2;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL misalign_ctrl cyc=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL misalign_out cyc=%0d got=%b want=%b", i, post_obs, post_exp); end
            if (i == 9) begin
                checks++;
                if (err_frame !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b want=1", err_frame); end
            end
        end
        checks++;
        if (err_frame !== 1'b1) begin failures++; $display("FAIL misalign_sticky got=%b want=1", err_frame); end
    endtask

    task automatic test_back_to_back();
        int beats, frames, vcnt, scnt, ecnt, dcnt;
        logic v;
        beats = 0; frames = 0; vcnt = 0; scnt = 0; ecnt = 0; dcnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (frames < 3) begin
                v = ($urandom_range(0, 3) != 0);
                if (v) beats++;
                tick(v, v && beats == 16, v && beats == 16 && frames == 2);
                if (v && beats == 16) begin beats = 0; frames++; end
            end else if (m_mode != 0) tick(1'b0, 1'b0, 1'b0);
            else break;
            checks += 2;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL b2b_ctrl cyc=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL b2b_out cyc=%0d got=%b want=%b", i, post_obs, post_exp); end
            if (pre_obs[5]) begin
                if (out_valid) vcnt++;
                if (out_sof) scnt++;
                if (out_eof) ecnt++;
            end
            if (pre_obs[4] && !pre_obs[6]) dcnt++;
        end
        checks += 4;
        if (vcnt != 48) begin failures++; $display("FAIL b2b_valid_count got=%0d want=48", vcnt); end
        if (scnt != 3) begin failures++; $display("FAIL b2b_sof_count got=%0d want=3", scnt); end
        if (ecnt != 3) begin failures++; $display("FAIL b2b_eof_count got=%0d want=3", ecnt); end
        if (dcnt != 19) begin failures++; $display("FAIL b2b_drain_cycles got=%0d want=19", dcnt); end
    endtask

    task automatic test_random();
        int beats, frames, len;
        logic v, l, f;
        beats = 0; frames = 0; len = 16;
        for (int i = 0; i < 600; i++) begin
            if (frames < 5) begin
                v = ($urandom_range(0, 2) != 0);
                if (v) beats++;
                l = v && beats == len;
                f = l && (frames == 4 || $urandom_range(0, 1) == 1);
                tick(v, l, f);
                if (l) begin beats = 0; frames++; len = ($urandom_range(0, 3) == 0) ? 12 : 16; end
            end else if (m_mode != 0) tick(1'b0, 1'b0, 1'b0);
            else break;
            checks += 2;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL rand_out cyc=%0d got=%b want=%b", i, post_obs, post_exp); end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 21; i++) begin
            tick(i < 16, i == 15, i == 15);
            checks += 2;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL rstdrain_ctrl cyc=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL rstdrain_out cyc=%0d got=%b want=%b", i, post_obs, post_exp); end
        end
        @(negedge clk);
        #2 clear_n = 1'b0;
        model_reset();
        #1;
        checks += 2;
        if ({in_ready, pipe_en, busy} !== 3'b100) begin
            failures++; $display("FAIL rstdrain_ctrl_now got=%b want=100", {in_ready, pipe_en, busy});
        end
        if ({out_valid, out_sof, out_eof, err_frame} !== 4'b0000) begin
            failures++; $display("FAIL rstdrain_out_now got=%b want=0000", {out_valid, out_sof, out_eof, err_frame});
        end
        @(negedge clk) clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks += 2;
            if (pre_obs !== pre_exp) begin failures++; $display("FAIL rstdrain_idle_ctrl cyc=%0d got=%b want=%b", i, pre_obs, pre_exp); end
            if (post_obs !== post_exp) begin failures++; $display("FAIL rstdrain_idle_out cyc=%0d got=%b want=%b", i, post_obs, post_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stage_sel();
        test_stall();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
